// File: rtl/perf_cntr_mc.sv
// perf_cntr_mc: multi-channel memory-mapped performance counters.
// Optional macro PERF_SNAPSHOT_EN: HI returns a shadow latched on LO read.
module perf_cntr_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              w_en_i,
    input  logic [NUM_CH-1:0] event_i,
    output logic [31:0]       rdata_o
);

    localparam int CH_W = ADDR_W - 4;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_LO   = 2'd1;
    localparam logic [1:0] REG_HI   = 2'd2;

    localparam logic [1:0] MODE_CLEAR = 2'd0;
    localparam logic [1:0] MODE_CYCLE = 2'd1;
    localparam logic [1:0] MODE_EVENT = 2'd2;

    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;

    logic [NUM_CH-1:0]            hit;
    logic [NUM_CH-1:0]            ctrl_wr;
    logic [NUM_CH-1:0]            inc;
    logic [NUM_CH-1:0]            wrap;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][1:0]       mode_q, mode_d;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [31:0]                  rdata_q, rdata_d;
    logic [63:0]                  cnt_ext;
`ifdef PERF_SNAPSHOT_EN
    logic [NUM_CH-1:0][31:0]      shadow_q, shadow_d;
`endif

    logic unused_ok;
    assign unused_ok = ^{addr_i[1:0], wdata_i[31:2]};

    assign ch_sel  = addr_i[ADDR_W-1:4];
    assign reg_sel = addr_i[3:2];
    assign rdata_o = rdata_q;

    // Channel select; indices beyond NUM_CH match nothing.
    always_comb begin
        hit     = '0;
        ctrl_wr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]     = (int'(ch_sel) == i);
            ctrl_wr[i] = hit[i] && w_en_i && (reg_sel == REG_CTRL);
        end
    end

    // Counter, mode and sticky overflow next-state; a CTRL write beats a wrap.
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        ovf_d  = ovf_q;
        inc    = '0;
        wrap   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            inc[i]  = (mode_q[i] == MODE_CYCLE)
                   || ((mode_q[i] == MODE_EVENT) && event_i[i]);
            wrap[i] = inc[i] && (&cnt_q[i]);
            if (mode_q[i] == MODE_CLEAR) begin
                cnt_d[i] = '0;
            end else if (inc[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (wrap[i]) begin
                ovf_d[i] = 1'b1;
            end
            if (ctrl_wr[i]) begin
                mode_d[i] = wdata_i[1:0];
                ovf_d[i]  = 1'b0;
            end
        end
    end

    // Read mux for the addressed register; LO read also feeds the shadow.
    always_comb begin
        rdata_d = '0;
        cnt_ext = '0;
`ifdef PERF_SNAPSHOT_EN
        shadow_d = shadow_q;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                cnt_ext = 64'(cnt_q[i]);
                unique case (reg_sel)
                    REG_CTRL: rdata_d = {29'b0, ovf_q[i], mode_q[i]};
                    REG_LO: begin
                        rdata_d = cnt_ext[31:0];
`ifdef PERF_SNAPSHOT_EN
                        shadow_d[i] = cnt_ext[63:32];
`endif
                    end
`ifdef PERF_SNAPSHOT_EN
                    REG_HI:   rdata_d = shadow_q[i];
`else
                    REG_HI:   rdata_d = cnt_ext[63:32];
`endif
                    default:  rdata_d = '0;
                endcase
            end
        end
    end

    // State registers; reset overrides writes and events.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            mode_q  <= '0;
            ovf_q   <= '0;
            rdata_q <= '0;
`ifdef PERF_SNAPSHOT_EN
            shadow_q <= '0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            rdata_q <= rdata_d;
`ifdef PERF_SNAPSHOT_EN
            shadow_q <= shadow_d;
`endif
        end
    end

endmodule

// File: tb/tb_perf_cntr_mc.sv
// tb_perf_cntr_mc: directed checks for perf_cntr_mc (NUM_CH=4, CNT_W=33).
// Inputs change on the falling edge; read data sampled 1 unit after rising.
module tb_perf_cntr_mc;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        w_en_i = 1'b0;
    logic [3:0]  event_i = '0;
    logic [31:0] rdata_o;

    int errors = 0;
    int checks = 0;

    logic [31:0]       d;
    logic [3:0][32:0]  pv;

    perf_cntr_mc #(.NUM_CH(4), .CNT_W(33), .ADDR_W(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .w_en_i  (w_en_i),
        .event_i (event_i),
        .rdata_o (rdata_o)
    );

    always #5 clk = ~clk;

    // Register byte address of channel ch, register r (0 CTRL, 1 LO, 2 HI).
    function automatic logic [7:0] ra(input int ch, input int r);
        return 8'(ch * 16 + r * 4);
    endfunction

    // Called at a falling edge; the next rising edge performs the write.
    task automatic wr(input logic [7:0] a, input logic [31:0] v);
        addr_i  = a;
        wdata_i = v;
        w_en_i  = 1'b1;
        @(negedge clk);
        w_en_i  = 1'b0;
    endtask

    // Returns the value held in the register just before the next rising edge.
    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        addr_i = a;
        @(posedge clk);
        #1 v = rdata_o;
        @(negedge clk);
    endtask

    // Preload one channel's counter, others zero.
    task automatic preload(input int ch, input logic [32:0] v);
        pv     = '0;
        pv[ch] = v;
        force dut.cnt_q = pv;
        #1;
        release dut.cnt_q;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i   = 1'b1;
        w_en_i  = 1'b0;
        event_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata: got %h want %h", rdata_o, 32'h0);
        end
        rd(ra(0, 0), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_ctrl0: got %h want %h", d, 32'h0);
        end
        rd(ra(0, 1), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rst_lo0: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_cycle();
        do_reset();
        wr(ra(0, 0), 32'd1);
        repeat (100) @(negedge clk);
        wr(ra(0, 0), 32'd3);
        rd(ra(0, 1), d);
        checks++;
        if (d !== 32'd101) begin
            errors++;
            $display("FAIL cyc_lo: got %0d want %0d", d, 101);
        end
        repeat (7) @(negedge clk);
        rd(ra(0, 1), d);
        checks++;
        if (d !== 32'd101) begin
            errors++;
            $display("FAIL cyc_hold: got %0d want %0d", d, 101);
        end
        rd(ra(0, 2), d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL cyc_hi: got %0d want %0d", d, 0);
        end
        rd(ra(0, 0), d);
        checks++;
        if (d !== 32'h3) begin
            errors++;
            $display("FAIL cyc_ctrl: got %h want %h", d, 32'h3);
        end
    endtask

    task automatic test_event();
        do_reset();
        wr(ra(1, 0), 32'd2);
        wr(ra(3, 0), 32'd2);
        for (int i = 0; i < 37; i++) begin
            event_i = (i < 10) ? 4'b1111 : 4'b0111;
            @(negedge clk);
            event_i = 4'b0000;
            @(negedge clk);
        end
        rd(ra(1, 1), d);
        checks++;
        if (d !== 32'd37) begin
            errors++;
            $display("FAIL evt_lo1: got %0d want %0d", d, 37);
        end
        rd(ra(3, 1), d);
        checks++;
        if (d !== 32'd10) begin
            errors++;
            $display("FAIL evt_lo3: got %0d want %0d", d, 10);
        end
        rd(ra(0, 1), d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL evt_lo0: got %0d want %0d", d, 0);
        end
        rd(ra(2, 1), d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL evt_lo2: got %0d want %0d", d, 0);
        end
        rd(ra(1, 2), d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL evt_hi1: got %0d want %0d", d, 0);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wr(ra(2, 0), 32'd1);
        preload(2, 33'h1_FFFF_FFFE);
        repeat (3) @(negedge clk);
        rd(ra(2, 1), d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL wrap_lo: got %h want %h", d, 32'd1);
        end
        rd(ra(2, 0), d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL wrap_ovf: got %h want %h", d, 32'h5);
        end
        wr(ra(2, 0), 32'd1);
        rd(ra(2, 0), d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL wrap_clr: got %h want %h", d, 32'h1);
        end
        preload(2, 33'h1_FFFF_FFFF);
        wr(ra(2, 0), 32'd1);
        rd(ra(2, 0), d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL wrap_wrwins: got %h want %h", d, 32'h1);
        end
        rd(ra(2, 1), d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL wrap_lo2: got %h want %h", d, 32'd1);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] hi_exp;
`ifdef PERF_SNAPSHOT_EN
        hi_exp = 32'd0;
`else
        hi_exp = 32'd1;
`endif
        do_reset();
        wr(ra(1, 0), 32'd1);
        preload(1, 33'h0_FFFF_FFFF);
        rd(ra(1, 1), d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL snap_lo: got %h want %h", d, 32'hFFFF_FFFF);
        end
        rd(ra(1, 2), d);
        checks++;
        if (d !== hi_exp) begin
            errors++;
            $display("FAIL snap_hi: got %h want %h", d, hi_exp);
        end
        rd(ra(1, 1), d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL snap_lo2: got %h want %h", d, 32'd1);
        end
        rd(ra(1, 2), d);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL snap_hi2: got %h want %h", d, 32'd1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(ra(0, 0), 32'd1);
        wr(ra(1, 0), 32'd3);
        wr(ra(2, 0), 32'd2);
        event_i = 4'b1111;
        repeat (5) @(negedge clk);
        rst_i   = 1'b1;
        w_en_i  = 1'b1;
        addr_i  = ra(3, 0);
        wdata_i = 32'd1;
        @(negedge clk);
        rst_i   = 1'b0;
        w_en_i  = 1'b0;
        checks++;
        if (rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL rmid_rdata: got %h want %h", rdata_o, 32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 3; r++) begin
                rd(ra(c, r), d);
                checks++;
                if (d !== 32'h0) begin
                    errors++;
                    $display("FAIL rmid_ch%0d_r%0d: got %h want %h",
                             c, r, d, 32'h0);
                end
            end
        end
        event_i = 4'b0000;
        wr(ra(0, 0), 32'd1);
        wr(ra(0, 1), 32'd2);
        wr(ra(4, 0), 32'd3);
        repeat (3) @(negedge clk);
        rd(ra(4, 0), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL oob_ctrl: got %h want %h", d, 32'h0);
        end
        rd(ra(4, 1), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL oob_lo: got %h want %h", d, 32'h0);
        end
        rd(8'h0C, d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL rsvd: got %h want %h", d, 32'h0);
        end
        rd(ra(0, 0), d);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL ign_wr_ctrl: got %h want %h", d, 32'h1);
        end
        rd(ra(0, 1), d);
        checks++;
        if (d !== 32'd9) begin
            errors++;
            $display("FAIL ign_wr_lo: got %0d want %0d", d, 9);
        end
    endtask

    task automatic test_clear_mode();
        do_reset();
        wr(ra(3, 0), 32'd1);
        preload(3, 33'h1_FFFF_FFFD);
        repeat (4) @(negedge clk);
        rd(ra(3, 0), d);
        checks++;
        if (d !== 32'h5) begin
            errors++;
            $display("FAIL clr_ovf_set: got %h want %h", d, 32'h5);
        end
        wr(ra(3, 0), 32'd0);
        rd(ra(3, 1), d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL clr_wrcyc: got %0d want %0d", d, 3);
        end
        rd(ra(3, 1), d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL clr_lo: got %0d want %0d", d, 0);
        end
        rd(ra(3, 0), d);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clr_ctrl: got %h want %h", d, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_cycle();
        test_event();
        test_wrap();
        test_snapshot();
        test_reset_mid();
        test_clear_mode();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
